// File: rtl/switch_conditioner.sv
// Conditions raw board switches for the picoMIPS core: per-bit synchroniser and
// debounce, plus registered rise/fall strobes and a data capture on the handshake bit.
module switch_conditioner #(
  parameter int N_SW            = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HS_BIT          = 8,
  parameter int DATA_W          = 8
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [N_SW-1:0]   switchesIn,
  output logic [N_SW-1:0]   switchesOut,
  output logic              handshakeRise,
  output logic              handshakeFall,
  output logic [DATA_W-1:0] dataOut
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0]  sync_q [SYNC_STAGES];
  logic [N_SW-1:0]  synced;
  logic [N_SW-1:0]  deb;
  logic [CNT_W-1:0] cnt [N_SW];
  logic             hs_prev;
  logic             rise;
  logic             fall;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= switchesIn;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Counter clears both on a return to the accepted level and on acceptance.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      deb <= '0;
      for (int unsigned i = 0; i < N_SW; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SW; i++) begin
        if (synced[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= synced[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign switchesOut = deb;

  always_comb begin
    rise = deb[HS_BIT] & ~hs_prev;
    fall = ~deb[HS_BIT] & hs_prev;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      hs_prev       <= 1'b0;
      handshakeRise <= 1'b0;
      handshakeFall <= 1'b0;
      dataOut       <= '0;
    end else begin
      hs_prev       <= deb[HS_BIT];
      handshakeRise <= rise;
      handshakeFall <= fall;
      if (rise) dataOut <= deb[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed scenarios plus randomized switch activity,
// compared each cycle against a sliding-window reference of the debounce rules.
module tb_switch_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HS   = 8;

  logic       clk = 1'b0;
  logic       nReset;
  logic [9:0] switchesIn;
  logic [9:0] switchesOut;
  logic       handshakeRise;
  logic       handshakeFall;
  logic [7:0] dataOut;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rise   = 0;
  int n_fall   = 0;

  logic [9:0] m_pipe[$];
  logic [9:0] m_hist[$];
  logic [9:0] m_d;
  logic       m_prev, m_rise, m_fall;
  logic [7:0] m_data;

  switch_conditioner #(
    .N_SW(10), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HS_BIT(HS), .DATA_W(8)
  ) dut (
    .clk(clk), .nReset(nReset), .switchesIn(switchesIn), .switchesOut(switchesOut),
    .handshakeRise(handshakeRise), .handshakeFall(handshakeFall), .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pipe = {};
    for (int k = 0; k < SYNC; k++) m_pipe.push_back('0);
    m_hist = {};
    m_d = '0; m_prev = 0; m_rise = 0; m_fall = 0; m_data = '0;
  endtask

  // A bit flips once the last DEB synced samples all disagree with its level.
  task automatic model_edge(input logic [9:0] raw);
    logic [9:0] s, dn;
    logic rn, fn, all_diff;
    s = m_pipe.pop_front();
    m_pipe.push_back(raw);
    m_hist.push_back(s);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    rn = m_d[HS] && !m_prev;
    fn = !m_d[HS] && m_prev;
    if (rn) m_data = m_d[7:0];
    m_prev = m_d[HS];
    dn = m_d;
    for (int i = 0; i < 10; i++) begin
      all_diff = (m_hist.size() == DEB);
      for (int j = 0; j < m_hist.size(); j++)
        if (m_hist[j][i] == m_d[i]) all_diff = 0;
      if (all_diff) dn[i] = ~m_d[i];
    end
    m_d = dn; m_rise = rn; m_fall = fn;
  endtask

  task automatic cyc(input logic [9:0] raw);
    switchesIn = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    check("sw", 32'(switchesOut), 32'(m_d));
    check("rise", 32'(handshakeRise), 32'(m_rise));
    check("fall", 32'(handshakeFall), 32'(m_fall));
    check("data", 32'(dataOut), 32'(m_data));
    check("excl", 32'(handshakeRise & handshakeFall), 32'd0);
    n_rise += int'(handshakeRise);
    n_fall += int'(handshakeFall);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sw"}, 32'(switchesOut), 32'd0);
    check({tag, "_rise"}, 32'(handshakeRise), 32'd0);
    check({tag, "_fall"}, 32'(handshakeFall), 32'd0);
    check({tag, "_data"}, 32'(dataOut), 32'd0);
  endtask

  task automatic async_reset();
    #2 nReset = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    nReset = 1'b1;
  endtask

  initial begin
    logic [9:0] target, raw;
    nReset = 1'b0;
    switchesIn = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    nReset = 1'b1;

    // Latency: visible after exactly SYNC+DEB edges, no strobes
    cyc(10'h000);
    n_rise = 0; n_fall = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(10'h0A5);
      if (i == 5) check("lat_before", 32'(switchesOut), 32'h0);
    end
    check("lat_after", 32'(switchesOut), 32'h0A5);
    check("lat_strobes", 32'(n_rise + n_fall), 32'd0);

    // Handshake capture, hold while high, fall leaves data alone
    repeat (8) cyc(10'h03C);
    n_rise = 0;
    repeat (8) cyc(10'h13C);
    check("hs_rise_cnt", 32'(n_rise), 32'd1);
    check("hs_data", 32'(dataOut), 32'h3C);
    repeat (8) cyc(10'h1FF);
    check("hs_hold_data", 32'(dataOut), 32'h3C);
    check("hs_hold_sw", 32'(switchesOut), 32'h1FF);
    n_fall = 0;
    repeat (8) cyc(10'h0FF);
    check("hs_fall_cnt", 32'(n_fall), 32'd1);
    check("hs_fall_data", 32'(dataOut), 32'h3C);

    // Mid-debounce reset, then rise 7 edges after release
    repeat (4) cyc(10'h1FF);
    async_reset();
    n_rise = 0;
    repeat (6) cyc(10'h1FF);
    check("rst_no_early_rise", 32'(n_rise), 32'd0);
    cyc(10'h1FF);
    check("rst_rise_at_7", 32'(handshakeRise), 32'd1);
    check("rst_rise_data", 32'(dataOut), 32'hFF);

    // Data and handshake changing on the same raw cycle
    repeat (8) cyc(10'h000);
    n_rise = 0;
    repeat (8) cyc(10'h111);
    check("simul_rise_cnt", 32'(n_rise), 32'd1);
    check("simul_data", 32'(dataOut), 32'h11);

    // Independence: bit 0 bouncing, bit 1 clean
    repeat (8) cyc(10'h000);
    for (int i = 1; i <= 6; i++) cyc(10'h002 | 10'(i & 1));
    check("indep_sw", 32'(switchesOut), 32'h002);

    // Glitch shorter than DEB synced cycles is rejected
    repeat (3) cyc(10'h00A);
    repeat (8) cyc(10'h002);
    check("glitch_sw", 32'(switchesOut), 32'h002);

    // Randomized activity with glitches and occasional asynchronous resets
    target = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) target = 10'($urandom);
      raw = target;
      if ($urandom_range(0, 9) == 0) raw = raw ^ (10'h1 << $urandom_range(0, 9));
      cyc(raw);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
